// File: rtl/drive_pkg.sv
// Shared constants and encodings for the drive command sequencer.
package drive_pkg;

  // Single-character drive commands received over the UART link
  localparam logic [7:0] CMD_FWD   = "w";
  localparam logic [7:0] CMD_REV   = "x";
  localparam logic [7:0] CMD_STOP  = "s";
  localparam logic [7:0] CMD_BRAKE = "b";
  localparam logic [7:0] CMD_LEFT  = "l";
  localparam logic [7:0] CMD_CTR   = "c";
  localparam logic [7:0] CMD_RIGHT = "r";
  localparam logic [7:0] ACK_BAD   = "?";

  localparam int DUTY_W = 16;

  typedef enum logic [2:0] {
    STOP,
    DEAD,
    FWD,
    REV,
    BRAKE
  } motorState_t;

  typedef enum logic {
    DIR_FWD,
    DIR_REV
  } dir_t;

endpackage

// File: rtl/drive_cmd_ctrl_if.sv
// Command/ack byte link plus the PWM and bridge drive outputs of the sequencer.
interface drive_cmd_ctrl_if;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic [15:0] motor_duty;
  logic        motor_a;
  logic        motor_b;
  logic [15:0] servo_duty;
  logic        failsafe;
  logic        ack_valid;
  logic [7:0]  ack_data;

  modport master (
    output rx_valid, rx_data,
    input  motor_duty, motor_a, motor_b, servo_duty, failsafe, ack_valid, ack_data
  );

  modport slave (
    input  rx_valid, rx_data,
    output motor_duty, motor_a, motor_b, servo_duty, failsafe, ack_valid, ack_data
  );
endinterface

// File: rtl/slew_step.sv
// One slew step: move cur toward target by at most step, never overshooting.
module slew_step (
  input  logic [15:0] cur,
  input  logic [15:0] target,
  input  logic [15:0] step,
  output logic [15:0] nextVal
);

  logic [15:0] diff;

  // Compare first so the unsigned subtraction can never wrap
  always_comb begin
    if (cur < target) begin
      diff    = target - cur;
      nextVal = cur + ((diff < step) ? diff : step);
    end else begin
      diff    = cur - target;
      nextVal = cur - ((diff < step) ? diff : step);
    end
  end

endmodule

// File: rtl/drive_cmd_ctrl.sv
// Drive command sequencer: decodes UART command bytes, slews motor and servo
// duty at the control tick rate, sequences reversal through dead-time and
// forces a ramp-down failsafe when the link goes quiet.
module drive_cmd_ctrl
  import drive_pkg::*;
#(
  parameter int unsigned TICK_DIV   = 50000,
  parameter int unsigned MOTOR_MAX  = 5000,
  parameter int unsigned MOTOR_STEP = 50,
  parameter int unsigned SERVO_MIN  = 1000,
  parameter int unsigned SERVO_CTR  = 1500,
  parameter int unsigned SERVO_MAX  = 2000,
  parameter int unsigned SERVO_STEP = 10,
  parameter int unsigned DEAD_TICKS = 20,
  parameter int unsigned WDT_TICKS  = 500
) (
  input logic             clk,
  input logic             rst,
  drive_cmd_ctrl_if.slave bus
);

  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DEAD_W = (DEAD_TICKS > 1) ? $clog2(DEAD_TICKS) : 1;
  localparam int WDT_W  = $clog2(WDT_TICKS + 1);

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [DEAD_W-1:0] DEAD_LAST = DEAD_W'(DEAD_TICKS - 1);
  localparam logic [WDT_W-1:0]  WDT_LAST  = WDT_W'(WDT_TICKS - 1);
  localparam logic [WDT_W-1:0]  WDT_SAT   = WDT_W'(WDT_TICKS);

  localparam logic [DUTY_W-1:0] MOTOR_MAX16  = DUTY_W'(MOTOR_MAX);
  localparam logic [DUTY_W-1:0] MOTOR_STEP16 = DUTY_W'(MOTOR_STEP);
  localparam logic [DUTY_W-1:0] SERVO_MIN16  = DUTY_W'(SERVO_MIN);
  localparam logic [DUTY_W-1:0] SERVO_CTR16  = DUTY_W'(SERVO_CTR);
  localparam logic [DUTY_W-1:0] SERVO_MAX16  = DUTY_W'(SERVO_MAX);
  localparam logic [DUTY_W-1:0] SERVO_STEP16 = DUTY_W'(SERVO_STEP);

  logic [TICK_W-1:0] tickCnt;
  logic              tick;
  logic              isFwd, isRev, isStop, isBrake, isLeft, isCtr, isRight, cmdOk;
  logic [DUTY_W-1:0] spdTgt;
  dir_t              dirTgt;
  logic [DUTY_W-1:0] srvTgt;
  logic [WDT_W-1:0]  wdtCnt;
  motorState_t       state;
  logic [DEAD_W-1:0] deadCnt;
  logic [DUTY_W-1:0] motorGoal;
  logic [DUTY_W-1:0] motorNext;
  logic [DUTY_W-1:0] servoNext;

  assign tick = (tickCnt == TICK_LAST);

  // Free-running control tick divider
  always_ff @(posedge clk or posedge rst) begin
    if (rst) tickCnt <= '0;
    else     tickCnt <= tick ? '0 : tickCnt + TICK_W'(1);
  end

  // Command byte decode, qualified by the receive strobe
  always_comb begin
    isFwd   = bus.rx_valid && (bus.rx_data == CMD_FWD);
    isRev   = bus.rx_valid && (bus.rx_data == CMD_REV);
    isStop  = bus.rx_valid && (bus.rx_data == CMD_STOP);
    isBrake = bus.rx_valid && (bus.rx_data == CMD_BRAKE);
    isLeft  = bus.rx_valid && (bus.rx_data == CMD_LEFT);
    isCtr   = bus.rx_valid && (bus.rx_data == CMD_CTR);
    isRight = bus.rx_valid && (bus.rx_data == CMD_RIGHT);
    cmdOk   = isFwd | isRev | isStop | isBrake | isLeft | isCtr | isRight;
  end

  // Echo each received byte back, or '?' when it is not a command
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.ack_valid <= 1'b0;
      bus.ack_data  <= '0;
    end else begin
      bus.ack_valid <= bus.rx_valid;
      if (bus.rx_valid) bus.ack_data <= cmdOk ? bus.rx_data : ACK_BAD;
    end
  end

  // Targets and link watchdog; a recognised command both kicks and applies
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      spdTgt       <= '0;
      dirTgt       <= DIR_FWD;
      srvTgt       <= SERVO_CTR16;
      wdtCnt       <= '0;
      bus.failsafe <= 1'b0;
    end else if (cmdOk) begin
      wdtCnt       <= '0;
      bus.failsafe <= 1'b0;
      if (isFwd) begin
        spdTgt <= MOTOR_MAX16;
        dirTgt <= DIR_FWD;
      end
      if (isRev) begin
        spdTgt <= MOTOR_MAX16;
        dirTgt <= DIR_REV;
      end
      if (isStop || isBrake) spdTgt <= '0;
      if (isLeft)  srvTgt <= SERVO_MIN16;
      if (isCtr)   srvTgt <= SERVO_CTR16;
      if (isRight) srvTgt <= SERVO_MAX16;
    end else if (tick && (wdtCnt != WDT_SAT)) begin
      wdtCnt <= wdtCnt + WDT_W'(1);
      if (wdtCnt == WDT_LAST) begin
        bus.failsafe <= 1'b1;
        spdTgt       <= '0;
        srvTgt       <= SERVO_CTR16;
      end
    end
  end

  // While driving, a direction change or zero target means ramp down first
  always_comb begin
    motorGoal = spdTgt;
    if ((state == FWD && dirTgt != DIR_FWD) || (state == REV && dirTgt != DIR_REV))
      motorGoal = '0;
  end

  slew_step uMotorSlew (
    .cur     (bus.motor_duty),
    .target  (motorGoal),
    .step    (MOTOR_STEP16),
    .nextVal (motorNext)
  );

  slew_step uServoSlew (
    .cur     (bus.servo_duty),
    .target  (srvTgt),
    .step    (SERVO_STEP16),
    .nextVal (servoNext)
  );

  // Servo duty follows its target one step per tick
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       bus.servo_duty <= SERVO_CTR16;
    else if (tick) bus.servo_duty <= servoNext;
  end

  // Motor FSM: brake acts at once, everything else moves on the tick
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= STOP;
      deadCnt        <= '0;
      bus.motor_duty <= '0;
      bus.motor_a    <= 1'b0;
      bus.motor_b    <= 1'b0;
    end else if (isBrake) begin
      state          <= BRAKE;
      bus.motor_duty <= '0;
      bus.motor_a    <= 1'b1;
      bus.motor_b    <= 1'b1;
    end else if (tick) begin
      case (state)
        STOP: begin
          bus.motor_duty <= '0;
          bus.motor_a    <= 1'b0;
          bus.motor_b    <= 1'b0;
          if (spdTgt != '0) begin
            state   <= DEAD;
            deadCnt <= '0;
          end
        end
        DEAD: begin
          if (deadCnt == DEAD_LAST) begin
            if (spdTgt == '0) begin
              state <= STOP;
            end else if (dirTgt == DIR_FWD) begin
              state       <= FWD;
              bus.motor_a <= 1'b1;
            end else begin
              state       <= REV;
              bus.motor_b <= 1'b1;
            end
          end else begin
            deadCnt <= deadCnt + DEAD_W'(1);
          end
        end
        FWD, REV: begin
          bus.motor_duty <= motorNext;
          if (motorNext == '0) begin
            state       <= STOP;
            bus.motor_a <= 1'b0;
            bus.motor_b <= 1'b0;
          end
        end
        BRAKE: begin
          if (spdTgt != '0) begin
            state       <= DEAD;
            deadCnt     <= '0;
            bus.motor_a <= 1'b0;
            bus.motor_b <= 1'b0;
          end
        end
        default: state <= STOP;
      endcase
    end
  end

endmodule

// File: tb/tb_drive_cmd_ctrl.sv
// Bench for drive_cmd_ctrl with a fast control tick and a tick-level
// reference model of the command/slew/dead-time/watchdog behaviour.
module tb_drive_cmd_ctrl;

  localparam int TD    = 4;
  localparam int MMAX  = 5000;
  localparam int MSTEP = 50;
  localparam int SMIN  = 1000;
  localparam int SCTR  = 1500;
  localparam int SMAX  = 2000;
  localparam int SSTEP = 10;
  localparam int DEADT = 20;
  localparam int WDT   = 500;

  localparam int M_IDLE  = 0;
  localparam int M_DEAD  = 1;
  localparam int M_DRIVE = 2;
  localparam int M_BRAKE = 3;

  localparam logic [43:0] RST_VEC = {16'd0, 2'b00, 16'd1500, 1'b0, 1'b0, 8'h00};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  drive_cmd_ctrl_if bus ();

  drive_cmd_ctrl #(.TICK_DIV(TD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [43:0] obs;
  assign obs = {bus.motor_duty, bus.motor_a, bus.motor_b, bus.servo_duty,
                bus.failsafe, bus.ack_valid, bus.ack_data};

  int errors = 0;
  int checks = 0;

  // Reference model state: motor as a signed velocity (+fwd / -rev)
  int mMode, mVel, mDrvDir, mDeadLeft, mSrv;
  int tSpd, tDir, tSrv, wdt;
  bit fs, ackV;
  logic [7:0] ackD;
  int cyc, nTicks;
  bit lastTick;

  function automatic int approach(int cur, int goal, int stp);
    if (cur < goal) return cur + (((goal - cur) < stp) ? (goal - cur) : stp);
    return cur - (((cur - goal) < stp) ? (cur - goal) : stp);
  endfunction

  function automatic bit known(logic [7:0] d);
    return d inside {8'h77, 8'h78, 8'h73, 8'h62, 8'h6C, 8'h63, 8'h72};
  endfunction

  function automatic logic [43:0] expVec();
    int   duty;
    logic a, b;
    duty = (mVel < 0) ? -mVel : mVel;
    a = (mMode == M_BRAKE) || (mMode == M_DRIVE && mDrvDir > 0);
    b = (mMode == M_BRAKE) || (mMode == M_DRIVE && mDrvDir < 0);
    return {duty[15:0], a, b, mSrv[15:0], fs, ackV, ackD};
  endfunction

  task automatic modelReset();
    mMode = M_IDLE; mVel = 0; mDrvDir = 1; mDeadLeft = 0; mSrv = SCTR;
    tSpd = 0; tDir = 1; tSrv = SCTR; wdt = 0; fs = 0; ackV = 0; ackD = 8'h00;
    cyc = 0; lastTick = 0;
  endtask

  // One clock edge of the model; decisions use the targets held before it
  task automatic modelEdge(bit v, logic [7:0] d);
    bit tk, k;
    int goal;
    tk = ((cyc % TD) == TD - 1);
    k  = v && known(d);
    cyc++;
    lastTick = tk;
    if (tk) nTicks++;
    if (tk) mSrv = approach(mSrv, tSrv, SSTEP);
    if (v && d == "b") begin
      mMode = M_BRAKE; mVel = 0;
    end else if (tk) begin
      case (mMode)
        M_IDLE, M_BRAKE: if (tSpd > 0) begin mMode = M_DEAD; mDeadLeft = DEADT; end
        M_DEAD: begin
          mDeadLeft--;
          if (mDeadLeft == 0) begin
            if (tSpd == 0) mMode = M_IDLE;
            else begin mMode = M_DRIVE; mDrvDir = tDir; mVel = 0; end
          end
        end
        default: begin
          goal = (tSpd == 0 || tDir != mDrvDir) ? 0 : tDir * tSpd;
          mVel = approach(mVel, goal, MSTEP);
          if (mVel == 0) mMode = M_IDLE;
        end
      endcase
    end
    if (k) begin
      wdt = 0; fs = 0;
      case (d)
        "w": begin tSpd = MMAX; tDir = 1; end
        "x": begin tSpd = MMAX; tDir = -1; end
        "s", "b": tSpd = 0;
        "l": tSrv = SMIN;
        "c": tSrv = SCTR;
        default: tSrv = SMAX;
      endcase
    end else if (tk && wdt < WDT) begin
      wdt++;
      if (wdt == WDT) begin fs = 1; tSpd = 0; tSrv = SCTR; end
    end
    ackV = v;
    if (v) ackD = k ? d : "?";
  endtask

  task automatic step(input bit v, input logic [7:0] d);
    bus.rx_valid = v;
    bus.rx_data  = d;
    @(posedge clk);
    modelEdge(v, d);
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic assertRst();
    #2 rst = 1'b1;
    #1;
  endtask

  task automatic releaseRst();
    @(negedge clk);
    rst = 1'b0;
    modelReset();
  endtask

  task automatic test_reset();
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (obs !== RST_VEC) begin
      errors++; $display("FAIL reset_values: got %h expected %h", obs, RST_VEC);
    end
    releaseRst();
    repeat (3 * TD) begin
      step(1'b0, 8'h00);
      checks++;
      if (obs !== expVec()) begin
        errors++; $display("FAIL reset_idle: got %h expected %h cyc %0d", obs, expVec(), cyc);
      end
    end
  endtask

  task automatic test_fwd_ramp();
    int t0, n;
    step(1'b1, "w");
    checks++;
    if ({bus.ack_valid, bus.ack_data} !== {1'b1, 8'h77}) begin
      errors++; $display("FAIL fwd_ack: got %b/%h expected 1/77", bus.ack_valid, bus.ack_data);
    end
    t0 = nTicks;
    while (nTicks < t0 + 121) begin
      step(1'b0, 8'h00);
      checks++;
      if (obs !== expVec()) begin
        errors++; $display("FAIL fwd_model: got %h expected %h cyc %0d", obs, expVec(), cyc);
      end
      n = nTicks - t0;
      if (lastTick && n >= 1 && n <= 20) begin
        checks++;
        if ({bus.motor_a, bus.motor_b, bus.motor_duty} !== {2'b00, 16'd0}) begin
          errors++; $display("FAIL fwd_dead: got ab=%b%b duty=%0d expected 00/0 tick %0d",
                             bus.motor_a, bus.motor_b, bus.motor_duty, n);
        end
      end
      if (lastTick && n >= 21) begin
        checks++;
        if ({bus.motor_a, bus.motor_b, bus.motor_duty} !== {2'b10, 16'(50 * (n - 21))}) begin
          errors++; $display("FAIL fwd_ramp: got ab=%b%b duty=%0d expected 10/%0d tick %0d",
                             bus.motor_a, bus.motor_b, bus.motor_duty, 50 * (n - 21), n);
        end
      end
    end
    checks++;
    if (bus.motor_duty !== 16'd5000) begin
      errors++; $display("FAIL fwd_full: got %0d expected 5000", bus.motor_duty);
    end
  endtask

  task automatic test_reverse();
    int t0, n, ed;
    logic [1:0] eab;
    step(1'b1, "x");
    checks++;
    if ({bus.ack_valid, bus.ack_data} !== {1'b1, 8'h78}) begin
      errors++; $display("FAIL rev_ack: got %b/%h expected 1/78", bus.ack_valid, bus.ack_data);
    end
    t0 = nTicks;
    while (nTicks < t0 + 221) begin
      step(1'b0, 8'h00);
      checks++;
      if (obs !== expVec()) begin
        errors++; $display("FAIL rev_model: got %h expected %h cyc %0d", obs, expVec(), cyc);
      end
      n   = nTicks - t0;
      ed  = (n < 100) ? 5000 - 50 * n : (n < 121) ? 0 : 50 * (n - 121);
      eab = (n < 100) ? 2'b10 : (n < 121) ? 2'b00 : 2'b01;
      if (lastTick) begin
        checks++;
        if ({bus.motor_a, bus.motor_b, bus.motor_duty} !== {eab, 16'(ed)}) begin
          errors++; $display("FAIL rev_profile: got ab=%b%b duty=%0d expected %b/%0d tick %0d",
                             bus.motor_a, bus.motor_b, bus.motor_duty, eab, ed, n);
        end
      end
    end
  endtask

  task automatic test_servo();
    int t0, n, es;
    step(1'b1, "r");
    t0 = nTicks;
    while (nTicks < t0 + 30) begin
      step(1'b0, 8'h00);
      checks++;
      if (obs !== expVec()) begin
        errors++; $display("FAIL servo_model: got %h expected %h cyc %0d", obs, expVec(), cyc);
      end
    end
    checks++;
    if (bus.servo_duty !== 16'd1800) begin
      errors++; $display("FAIL servo_right: got %0d expected 1800", bus.servo_duty);
    end
    step(1'b1, "l");
    t0 = nTicks;
    while (nTicks < t0 + 90) begin
      step(1'b0, 8'h00);
      n  = nTicks - t0;
      es = (1800 - 10 * n > 1000) ? 1800 - 10 * n : 1000;
      checks++;
      if (bus.servo_duty !== 16'(es)) begin
        errors++; $display("FAIL servo_left: got %0d expected %0d tick %0d", bus.servo_duty, es, n);
      end
    end
  endtask

  task automatic test_watchdog();
    int t0, n;
    step(1'b1, "w");
    t0 = nTicks;
    while (nTicks < t0 + 650) begin
      step(1'b0, 8'h00);
      checks++;
      if (obs !== expVec()) begin
        errors++; $display("FAIL wdt_model: got %h expected %h cyc %0d", obs, expVec(), cyc);
      end
      n = nTicks - t0;
      if (lastTick && (n == 499 || n == 500)) begin
        checks++;
        if (bus.failsafe !== (n == 500)) begin
          errors++; $display("FAIL wdt_edge: got %b expected %b tick %0d", bus.failsafe, n == 500, n);
        end
      end
    end
    checks++;
    if ({bus.failsafe, bus.motor_a, bus.motor_b, bus.motor_duty, bus.servo_duty} !==
        {3'b100, 16'd0, 16'd1500}) begin
      errors++; $display("FAIL wdt_safe: got fs=%b ab=%b%b duty=%0d servo=%0d expected 1/00/0/1500",
                         bus.failsafe, bus.motor_a, bus.motor_b, bus.motor_duty, bus.servo_duty);
    end
    step(1'b1, "c");
    checks++;
    if ({bus.failsafe, bus.ack_valid, bus.ack_data} !== {2'b01, 8'h63}) begin
      errors++; $display("FAIL wdt_clear: got fs=%b ack=%b/%h expected 0/1/63",
                         bus.failsafe, bus.ack_valid, bus.ack_data);
    end
  endtask

  task automatic test_coincident();
    while ((cyc % TD) != TD - 1) begin
      step(1'b0, 8'h00);
      checks++;
      if (obs !== expVec()) begin
        errors++; $display("FAIL coin_model: got %h expected %h cyc %0d", obs, expVec(), cyc);
      end
    end
    step(1'b1, "r");
    checks++;
    if (bus.servo_duty !== 16'd1500) begin
      errors++; $display("FAIL coin_old_target: got %0d expected 1500", bus.servo_duty);
    end
    repeat (TD) step(1'b0, 8'h00);
    checks++;
    if (bus.servo_duty !== 16'd1510) begin
      errors++; $display("FAIL coin_new_target: got %0d expected 1510", bus.servo_duty);
    end
  endtask

  task automatic test_back_to_back();
    int t0;
    step(1'b1, "l");
    step(1'b1, "r");
    checks++;
    if ({bus.ack_valid, bus.ack_data} !== {1'b1, 8'h72}) begin
      errors++; $display("FAIL b2b_ack: got %b/%h expected 1/72", bus.ack_valid, bus.ack_data);
    end
    t0 = nTicks;
    while (nTicks < t0 + 60) begin
      step(1'b0, 8'h00);
      checks++;
      if (obs !== expVec()) begin
        errors++; $display("FAIL b2b_model: got %h expected %h cyc %0d", obs, expVec(), cyc);
      end
    end
    checks++;
    if (bus.servo_duty !== 16'd2000) begin
      errors++; $display("FAIL b2b_servo: got %0d expected 2000", bus.servo_duty);
    end
  endtask

  task automatic test_brake_bad();
    int t0, tb, n;
    step(1'b1, "w");
    t0 = nTicks;
    while (nTicks < t0 + 25) begin
      step(1'b0, 8'h00);
      checks++;
      if (obs !== expVec()) begin
        errors++; $display("FAIL brake_model: got %h expected %h cyc %0d", obs, expVec(), cyc);
      end
    end
    checks++;
    if (bus.motor_duty !== 16'd200) begin
      errors++; $display("FAIL brake_preramp: got %0d expected 200", bus.motor_duty);
    end
    step(1'b1, "b");
    checks++;
    if ({bus.motor_a, bus.motor_b, bus.motor_duty} !== {2'b11, 16'd0}) begin
      errors++; $display("FAIL brake_entry: got ab=%b%b duty=%0d expected 11/0",
                         bus.motor_a, bus.motor_b, bus.motor_duty);
    end
    tb = nTicks;
    repeat (10 * TD) step(1'b0, 8'h00);
    step(1'b1, "q");
    checks++;
    if ({bus.ack_valid, bus.ack_data} !== {1'b1, 8'h3F}) begin
      errors++; $display("FAIL bad_ack: got %b/%h expected 1/3f", bus.ack_valid, bus.ack_data);
    end
    while (nTicks < tb + 500) begin
      step(1'b0, 8'h00);
      checks++;
      if (obs !== expVec()) begin
        errors++; $display("FAIL bad_model: got %h expected %h cyc %0d", obs, expVec(), cyc);
      end
      n = nTicks - tb;
      if (lastTick && (n == 499 || n == 500)) begin
        checks++;
        if (bus.failsafe !== (n == 500)) begin
          errors++; $display("FAIL bad_no_kick: got %b expected %b tick %0d", bus.failsafe, n == 500, n);
        end
      end
    end
    checks++;
    if ({bus.motor_a, bus.motor_b} !== 2'b11) begin
      errors++; $display("FAIL brake_hold: got %b%b expected 11", bus.motor_a, bus.motor_b);
    end
  endtask

  task automatic test_reset_mid();
    int t0;
    step(1'b1, "w");
    t0 = nTicks;
    while (nTicks < t0 + 10) step(1'b0, 8'h00);
    assertRst();
    checks++;
    if (obs !== RST_VEC) begin
      errors++; $display("FAIL rst_dead: got %h expected %h", obs, RST_VEC);
    end
    releaseRst();
    step(1'b1, "w");
    t0 = nTicks;
    while (nTicks < t0 + 71) begin
      step(1'b0, 8'h00);
      checks++;
      if (obs !== expVec()) begin
        errors++; $display("FAIL rst_model: got %h expected %h cyc %0d", obs, expVec(), cyc);
      end
    end
    checks++;
    if ({bus.motor_a, bus.motor_duty} !== {1'b1, 16'd2500}) begin
      errors++; $display("FAIL rst_preramp: got a=%b duty=%0d expected 1/2500", bus.motor_a, bus.motor_duty);
    end
    assertRst();
    checks++;
    if (obs !== RST_VEC) begin
      errors++; $display("FAIL rst_ramp: got %h expected %h", obs, RST_VEC);
    end
    releaseRst();
  endtask

  task automatic test_random();
    logic [7:0] tbl [8];
    logic [7:0] d;
    int gap;
    tbl = '{8'h77, 8'h78, 8'h73, 8'h62, 8'h6C, 8'h63, 8'h72, 8'h71};
    for (int i = 0; i < 300; i++) begin
      d = ($urandom_range(0, 9) < 9) ? tbl[$urandom_range(0, 7)] : 8'($urandom_range(0, 255));
      step(1'b1, d);
      checks++;
      if (obs !== expVec()) begin
        errors++; $display("FAIL rand_cmd: got %h expected %h cyc %0d", obs, expVec(), cyc);
      end
      gap = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 40);
      for (int g = 0; g < gap; g++) begin
        step(1'b0, 8'($urandom_range(0, 255)));
        checks++;
        if (obs !== expVec()) begin
          errors++; $display("FAIL rand_idle: got %h expected %h cyc %0d", obs, expVec(), cyc);
        end
      end
    end
  endtask

  initial begin
    nTicks = 0;
    modelReset();
    test_reset();
    test_fwd_ramp();
    test_reverse();
    test_servo();
    test_watchdog();
    test_coincident();
    test_back_to_back();
    test_brake_bad();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
